// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-tick divider, h/v counters, registered coordinates and
// display-active flag, plus hsync/vsync through a short clk_i-rate delay line.
module vga_timing_gen #(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        disp_active_o,
  output logic [10:0] xcol_o,
  output logic [10:0] yrow_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        pix_tick_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_OFF = ~SYNC_POL;

  logic [4:0]  div_reg;
  logic [10:0] h_reg, v_reg;
  logic [10:0] h_next, v_next;
  logic        tick, h_wrap, v_wrap;
  logic        disp_reg, disp_next;
  logic        hs_raw_reg, hs_raw_next;
  logic        vs_raw_reg, vs_raw_next;
  logic        pix_tick_reg, frame_start_reg;

  always_comb begin
    tick   = (div_reg == DIV_LAST);
    h_wrap = (h_reg == H_LAST);
    v_wrap = (v_reg == V_LAST);
    h_next = h_reg;
    v_next = v_reg;
    if (tick) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = v_wrap ? 11'd0 : v_reg + 11'd1;
      end else begin
        h_next = h_reg + 11'd1;
      end
    end
    // Flags are decoded from the post-update counters so they align with xcol/yrow.
    disp_next   = (h_next < H_VIS) && (v_next < V_VIS);
    hs_raw_next = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : SYNC_OFF;
    vs_raw_next = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : SYNC_OFF;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_reg         <= '0;
      h_reg           <= '0;
      v_reg           <= '0;
      disp_reg        <= 1'b0;
      hs_raw_reg      <= SYNC_OFF;
      vs_raw_reg      <= SYNC_OFF;
      pix_tick_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg         <= tick ? 5'd0 : div_reg + 5'd1;
      pix_tick_reg    <= tick;
      frame_start_reg <= tick && h_wrap && v_wrap;
      if (tick) begin
        h_reg      <= h_next;
        v_reg      <= v_next;
        disp_reg   <= disp_next;
        hs_raw_reg <= hs_raw_next;
        vs_raw_reg <= vs_raw_next;
      end
    end
  end

  assign xcol_o        = h_reg;
  assign yrow_o        = v_reg;
  assign disp_active_o = disp_reg;
  assign pix_tick_o    = pix_tick_reg;
  assign frame_start_o = frame_start_reg;

  // Sync delay runs at clk_i rate to match the colour stage's register, not the tick.
  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hsync_o = hs_raw_reg;
      assign vsync_o = vs_raw_reg;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_dly_reg;
      logic [SYNC_DELAY-1:0] vs_dly_reg;
      for (genvar gi = 0; gi < SYNC_DELAY; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
              hs_dly_reg[gi] <= SYNC_OFF;
              vs_dly_reg[gi] <= SYNC_OFF;
            end else begin
              hs_dly_reg[gi] <= hs_raw_reg;
              vs_dly_reg[gi] <= vs_raw_reg;
            end
          end
        end else begin : g_rest
          always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
              hs_dly_reg[gi] <= SYNC_OFF;
              vs_dly_reg[gi] <= SYNC_OFF;
            end else begin
              hs_dly_reg[gi] <= hs_dly_reg[gi-1];
              vs_dly_reg[gi] <= vs_dly_reg[gi-1];
            end
          end
        end
      end
      assign hsync_o = hs_dly_reg[SYNC_DELAY-1];
      assign vsync_o = vs_dly_reg[SYNC_DELAY-1];
    end
  endgenerate

endmodule
